// File: rtl/control_pkg.sv
// control_pkg: shared state, select and command encodings for the multicycle control unit
package control_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN
    } state_t;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;
    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] OP_DP = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the data-processing cmd/S bits to ALUControl, FlagW and NoWrite
module alu_decoder
    import control_pkg::*;
(
    input  logic       ALUOp,
    input  logic [4:0] Funct,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       NoWrite
);
    logic [3:0] cmd;
    logic       is_cmp;
    logic       is_addsub;
    assign cmd = Funct[4:1];
    assign is_cmp = cmd == CMD_CMP;
    assign is_addsub = (cmd == CMD_ADD) || (cmd == CMD_SUB);
    assign ALUControl = !ALUOp ? ALU_ADD :
                        (cmd == CMD_SUB || is_cmp) ? ALU_SUB :
                        cmd == CMD_AND ? ALU_AND :
                        cmd == CMD_ORR ? ALU_ORR : ALU_ADD;
    assign FlagW = !ALUOp ? 2'b00 : is_cmp ? 2'b11 : {Funct[0], Funct[0] & is_addsub};
    assign NoWrite = ALUOp & is_cmp;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing ARMv4-subset instructions and driving datapath selects
module multicycle_control
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic       NoWrite,
    output logic [1:0] FlagW,
    output logic       Illegal
);
    state_t state, next;
    logic   aluop;
    logic   branch;
    logic   dec_nowrite;
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= FETCH;
        else state <= next;
    always_comb begin
        next = FETCH;
        case (state)
            FETCH:    next = DECODE;
            DECODE:   next = Op == OP_MEM ? MEMADR :
                             Op == OP_BR  ? BRANCH :
                             Op == OP_ILL ? UNKNOWN :
                             Funct[5]     ? EXECUTEI : EXECUTER;
            MEMADR:   next = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  next = MEMWB;
            EXECUTER: next = ALUWB;
            EXECUTEI: next = ALUWB;
            default:  next = FETCH;
        endcase
    end
    // Unreachable encodings fall to the all-zero default, so no write request can leak
    always_comb begin
        IRWrite = 1'b0;
        NextPC = 1'b0;
        AdrSrc = 1'b0;
        ALUSrcA = 1'b0;
        ALUSrcB = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        RegW = 1'b0;
        MemW = 1'b0;
        branch = 1'b0;
        aluop = 1'b0;
        Illegal = 1'b0;
        case (state)
            FETCH: begin
                IRWrite = 1'b1;
                NextPC = 1'b1;
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            MEMADR:   ALUSrcB = SRCB_IMM;
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegW = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW = 1'b1;
            end
            EXECUTER: aluop = 1'b1;
            EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                aluop = 1'b1;
            end
            ALUWB:    RegW = 1'b1;
            BRANCH: begin
                ALUSrcB = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch = 1'b1;
            end
            UNKNOWN:  Illegal = 1'b1;
            default:  ;
        endcase
    end
    alu_decoder u_alu_decoder (
        .ALUOp      (aluop),
        .Funct      (Funct[4:0]),
        .ALUControl (ALUControl),
        .FlagW      (FlagW),
        .NoWrite    (dec_nowrite)
    );
    // CMP keeps NoWrite through writeback so the gated register write stays off
    assign NoWrite = dec_nowrite | (state == ALUWB && Funct[4:1] == CMD_CMP);
    assign PCS = ((Rd == 4'd15) & RegW) | branch;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-cycle output checks of the multicycle control FSM
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b0;
    logic [3:0] Rd = 4'd0;
    logic       IRWrite, NextPC, AdrSrc, ALUSrcA, PCS, RegW, MemW, NoWrite, Illegal;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagW;
    logic [16:0] obs;
    logic [16:0] F, D;
    int compared = 0;
    int mismatched = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .FlagW(FlagW),
        .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    assign obs = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
                  PCS, RegW, MemW, NoWrite, FlagW, Illegal};

    // Packs hand-written field values in the same order as obs
    function automatic logic [16:0] v(input int ir, input int np, input int as, input int sa,
                                      input int sb, input int rs, input int ac, input int pcs,
                                      input int rw, input int mw, input int nw, input int fw,
                                      input int il);
        v = {ir[0], np[0], as[0], sa[0], sb[1:0], rs[1:0], ac[1:0],
             pcs[0], rw[0], mw[0], nw[0], fw[1:0], il[0]};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        #2;
        compared++;
        if (obs !== F) begin
            mismatched++;
            $display("FAIL reset_async got %h want %h", obs, F);
        end
        @(posedge clk);
        @(negedge clk);
        compared++;
        if (obs !== F) begin
            mismatched++;
            $display("FAIL reset_held got %h want %h", obs, F);
        end
        reset = 1'b1;
        #1;
        compared++;
        if (obs !== F) begin
            mismatched++;
            $display("FAIL reset_release got %h want %h", obs, F);
        end
        @(negedge clk);
        compared++;
        if (obs !== D) begin
            mismatched++;
            $display("FAIL reset_first_edge got %h want %h", obs, D);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [16:0] e [5];
        e = '{F, D, v(0,0,0,0,0,0,0,0,0,0,0,0,0), v(0,0,0,0,0,0,0,0,1,0,0,0,0), F};
        Op = 2'b00; Funct = 6'b001000; Rd = 4'd1;
        foreach (e[i]) begin
            compared++;
            if (obs !== e[i]) begin
                mismatched++;
                $display("FAIL add cyc%0d got %h want %h", i, obs, e[i]);
            end
            if (i < 4) @(negedge clk);
        end
    endtask

    task automatic test_dp_decode();
        logic [5:0]  fn [6];
        logic [3:0]  rd [6];
        logic [16:0] ex [6];
        logic [16:0] wb [6];
        logic [16:0] e [5];
        fn = '{6'b000101, 6'b100001, 6'b011000, 6'b001111, 6'b010100, 6'b101001};
        rd = '{4'd15, 4'd2, 4'd4, 4'd5, 4'd0, 4'd7};
        ex = '{v(0,0,0,0,0,0,1,0,0,0,0,3,0), v(0,0,0,0,1,0,2,0,0,0,0,2,0),
               v(0,0,0,0,0,0,3,0,0,0,0,0,0), v(0,0,0,0,0,0,0,0,0,0,0,2,0),
               v(0,0,0,0,0,0,1,0,0,0,1,3,0), v(0,0,0,0,1,0,0,0,0,0,0,3,0)};
        wb = '{v(0,0,0,0,0,0,0,1,1,0,0,0,0), v(0,0,0,0,0,0,0,0,1,0,0,0,0),
               v(0,0,0,0,0,0,0,0,1,0,0,0,0), v(0,0,0,0,0,0,0,0,1,0,0,0,0),
               v(0,0,0,0,0,0,0,0,1,0,1,0,0), v(0,0,0,0,0,0,0,0,1,0,0,0,0)};
        foreach (fn[k]) begin
            e = '{F, D, ex[k], wb[k], F};
            Op = 2'b00; Funct = fn[k]; Rd = rd[k];
            foreach (e[i]) begin
                compared++;
                if (obs !== e[i]) begin
                    mismatched++;
                    $display("FAIL dp funct=%b cyc%0d got %h want %h", fn[k], i, obs, e[i]);
                end
                if (i < 4) @(negedge clk);
            end
        end
    endtask

    task automatic test_ldr();
        logic [16:0] e [6];
        e = '{F, D, v(0,0,0,0,1,0,0,0,0,0,0,0,0), v(0,0,1,0,0,0,0,0,0,0,0,0,0),
              v(0,0,0,0,0,1,0,1,1,0,0,0,0), F};
        Op = 2'b01; Funct = 6'b011001; Rd = 4'd15;
        foreach (e[i]) begin
            compared++;
            if (obs !== e[i]) begin
                mismatched++;
                $display("FAIL ldr cyc%0d got %h want %h", i, obs, e[i]);
            end
            if (i < 5) @(negedge clk);
        end
    endtask

    task automatic test_str();
        logic [16:0] e [5];
        e = '{F, D, v(0,0,0,0,1,0,0,0,0,0,0,0,0), v(0,0,1,0,0,0,0,0,0,1,0,0,0), F};
        Op = 2'b01; Funct = 6'b011000; Rd = 4'd3;
        foreach (e[i]) begin
            compared++;
            if (obs !== e[i]) begin
                mismatched++;
                $display("FAIL str cyc%0d got %h want %h", i, obs, e[i]);
            end
            if (i < 4) @(negedge clk);
        end
    endtask

    task automatic test_cmp_imm();
        logic [16:0] e [5];
        e = '{F, D, v(0,0,0,0,1,0,1,0,0,0,1,3,0), v(0,0,0,0,0,0,0,0,1,0,1,0,0), F};
        Op = 2'b00; Funct = 6'b110101; Rd = 4'd0;
        foreach (e[i]) begin
            compared++;
            if (obs !== e[i]) begin
                mismatched++;
                $display("FAIL cmp_imm cyc%0d got %h want %h", i, obs, e[i]);
            end
            if (i < 4) @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [16:0] e [4];
        e = '{F, D, v(0,0,0,0,1,2,0,1,0,0,0,0,0), F};
        Op = 2'b10; Funct = 6'b100000; Rd = 4'd6;
        foreach (e[i]) begin
            compared++;
            if (obs !== e[i]) begin
                mismatched++;
                $display("FAIL branch cyc%0d got %h want %h", i, obs, e[i]);
            end
            if (i < 3) @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        logic [16:0] e [4];
        e = '{F, D, v(0,0,0,0,0,0,0,0,0,0,0,0,1), F};
        Op = 2'b11; Funct = 6'b101001; Rd = 4'd15;
        foreach (e[i]) begin
            compared++;
            if (obs !== e[i]) begin
                mismatched++;
                $display("FAIL illegal cyc%0d got %h want %h", i, obs, e[i]);
            end
            if (i < 3) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] ma;
        ma = v(0,0,0,0,1,0,0,0,0,0,0,0,0);
        Op = 2'b01; Funct = 6'b011000; Rd = 4'd9;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (obs !== ma) begin
            mismatched++;
            $display("FAIL rmid_memadr got %h want %h", obs, ma);
        end
        #2 reset = 1'b0;
        #1;
        compared++;
        if (obs !== F) begin
            mismatched++;
            $display("FAIL rmid_async got %h want %h", obs, F);
        end
        @(negedge clk);
        compared++;
        if (obs !== F || MemW !== 1'b0 || RegW !== 1'b0) begin
            mismatched++;
            $display("FAIL rmid_held got %h want %h", obs, F);
        end
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if (obs !== D) begin
            mismatched++;
            $display("FAIL rmid_restart got %h want %h", obs, D);
        end
    endtask

    initial begin
        F = v(1,1,0,1,2,2,0,0,0,0,0,0,0);
        D = v(0,0,0,1,2,2,0,0,0,0,0,0,0);
        @(negedge clk);
        test_reset();
        test_add();
        test_dp_decode();
        test_ldr();
        test_str();
        test_cmp_imm();
        test_branch();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
